bpu_update_unit: RTL and testbench

Write-side companion to the branch predictor: carries the fetch-time prediction snapshot (PHT index/counter, BTB hit, predicted direction/target) down the IF→ID→EX shadow pipeline, compares it with the branch outcome resolved in EX, and issues registered PHT/GHR/BTB/RAS update strobes plus a mispredict redirect one cycle later. It sits between the EX stage and the predictor's write ports.

---
 rtl/bpu_update_if.sv | 47 ++++
 rtl/bpu_update_unit.sv | 165 ++++++++++++++++
 tb/tb_bpu_update_unit.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bpu_update_if.sv
// Signal bundle between the fetch/EX pipeline and the branch-predictor update unit.
// IF_Valid qualifies the fetch snapshot; each *_En/_Inst output and Mispredict is a one-cycle pulse whose data fields are zero while it is low.
interface bpu_update_if;
  logic        Stall;
  logic        Flush;
  logic        IF_Valid;
  logic [10:0] IF_PHT_Read_Index;
  logic [1:0]  IF_PHT_Read_Data;
  logic        IF_BTB_Hit;
  logic        IF_Pred_Taken;
  logic [31:0] IF_Pred_Target;
  logic [2:0]  EX_Br_Type;
  logic [31:0] EX_PC;
  logic        EX_Taken;
  logic [31:0] EX_Target;

  logic [10:0] PHT_Write_Index;
  logic [1:0]  PHT_Write_Data;
  logic        PHT_Write_En;
  logic        GHR_Write_Data;
  logic        GHR_Write_En;
  logic [31:0] BTB_Write_Addr;
  logic [31:0] BTB_Write_Data;
  logic        BTB_Write_En;
  logic        RAS_CALL_Inst;
  logic [31:0] RAS_CALL_Inst_nextPC;
  logic        RAS_RET_Inst_EX;
  logic        Branch_Taken__EX_MEM;
  logic        Mispredict;
  logic [31:0] Redirect_PC;

  modport slave (
    input  Stall, Flush, IF_Valid, IF_PHT_Read_Index, IF_PHT_Read_Data, IF_BTB_Hit,
           IF_Pred_Taken, IF_Pred_Target, EX_Br_Type, EX_PC, EX_Taken, EX_Target,
    output PHT_Write_Index, PHT_Write_Data, PHT_Write_En, GHR_Write_Data, GHR_Write_En,
           BTB_Write_Addr, BTB_Write_Data, BTB_Write_En, RAS_CALL_Inst, RAS_CALL_Inst_nextPC,
           RAS_RET_Inst_EX, Branch_Taken__EX_MEM, Mispredict, Redirect_PC
  );

  modport master (
    output Stall, Flush, IF_Valid, IF_PHT_Read_Index, IF_PHT_Read_Data, IF_BTB_Hit,
           IF_Pred_Taken, IF_Pred_Target, EX_Br_Type, EX_PC, EX_Taken, EX_Target,
    input  PHT_Write_Index, PHT_Write_Data, PHT_Write_En, GHR_Write_Data, GHR_Write_En,
           BTB_Write_Addr, BTB_Write_Data, BTB_Write_En, RAS_CALL_Inst, RAS_CALL_Inst_nextPC,
           RAS_RET_Inst_EX, Branch_Taken__EX_MEM, Mispredict, Redirect_PC
  );
endinterface

// File: rtl/bpu_update_unit.sv
// Carries the fetch-time prediction down an ID/EX shadow pipe and, when the EX branch
// resolves, issues registered PHT/GHR/BTB/RAS update pulses plus a mispredict redirect.
module bpu_update_unit (
  input logic         CLK,
  input logic         RST,
  bpu_update_if.slave bus
);

  typedef struct packed {
    logic        valid;
    logic [10:0] index;
    logic [1:0]  ctr;
    logic        hit;
    logic        pred_taken;
    logic [31:0] pred_target;
  } snap_t;

  typedef struct packed {
    logic        pht_we;
    logic [10:0] pht_idx;
    logic [1:0]  pht_data;
    logic        ghr_we;
    logic        ghr_data;
    logic        btb_we;
    logic [31:0] btb_addr;
    logic [31:0] btb_data;
    logic        ras_call;
    logic [31:0] ras_npc;
    logic        ras_ret;
    logic        br_taken;
    logic        mispred;
    logic [31:0] redirect;
  } upd_t;

  snap_t       id_q, id_d, ex_q, ex_d;
  upd_t        out_q, out_d;
  logic        byp_vld_q, byp_vld_d;
  logic [10:0] byp_idx_q, byp_idx_d;
  logic [1:0]  byp_ctr_q, byp_ctr_d;

  logic        is_cond, is_jal, is_jalr, is_call, is_ret, is_br;
  logic        fire, taken, btb_need, mispred;
  logic [1:0]  base_ctr, new_ctr, tag;
  logic [31:0] seq_pc;

  assign is_cond = (bus.EX_Br_Type == 3'b001);
  assign is_jal  = (bus.EX_Br_Type == 3'b010);
  assign is_jalr = (bus.EX_Br_Type == 3'b011);
  assign is_call = (bus.EX_Br_Type == 3'b100);
  assign is_ret  = (bus.EX_Br_Type == 3'b101);
  assign is_br   = is_cond | is_jal | is_jalr | is_call | is_ret;
  assign fire    = !bus.Stall && ex_q.valid && is_br;
  // Only conditional branches can resolve not-taken; jumps/calls/returns always redirect.
  assign taken   = is_cond ? bus.EX_Taken : 1'b1;
  assign seq_pc  = bus.EX_PC + 32'd4;

  // Back-to-back updates to one index start from the count just written, not the stale fetch read.
  assign base_ctr = (byp_vld_q && (byp_idx_q == ex_q.index)) ? byp_ctr_q : ex_q.ctr;
  assign btb_need = taken && (!ex_q.hit || (ex_q.pred_target != bus.EX_Target) ||
                              (!ex_q.pred_taken && !is_cond));
  assign mispred  = (ex_q.pred_taken != taken) ||
                    (taken && (ex_q.pred_target[31:2] != bus.EX_Target[31:2]));

  always_comb begin
    new_ctr = base_ctr;
    if (taken) begin
      if (base_ctr != 2'b11) new_ctr = base_ctr + 2'd1;
    end else begin
      if (base_ctr != 2'b00) new_ctr = base_ctr - 2'd1;
    end
  end

  always_comb begin
    tag = 2'b00;
    if (is_jal || is_call) tag = 2'b01;
    else if (is_jalr)      tag = 2'b10;
    else if (is_ret)       tag = 2'b11;
  end

  always_comb begin
    id_d = id_q;
    ex_d = ex_q;
    if (!bus.Stall) begin
      id_d = '{valid: bus.IF_Valid, index: bus.IF_PHT_Read_Index, ctr: bus.IF_PHT_Read_Data,
               hit: bus.IF_BTB_Hit, pred_taken: bus.IF_Pred_Taken,
               pred_target: bus.IF_Pred_Target};
      ex_d = id_q;
    end
    if (bus.Flush) begin
      id_d.valid = 1'b0;
      ex_d.valid = 1'b0;
    end
  end

  always_comb begin
    byp_vld_d = byp_vld_q;
    byp_idx_d = byp_idx_q;
    byp_ctr_d = byp_ctr_q;
    if (!bus.Stall) begin
      byp_vld_d = fire && is_cond;
      byp_idx_d = ex_q.index;
      byp_ctr_d = new_ctr;
    end
  end

  always_comb begin
    out_d = '0;
    if (fire) begin
      out_d.br_taken = taken;
      out_d.mispred  = mispred;
      out_d.redirect = taken ? {bus.EX_Target[31:2], 2'b00} : seq_pc;
      out_d.ras_ret  = is_ret;
      if (is_cond) begin
        out_d.pht_we   = 1'b1;
        out_d.pht_idx  = ex_q.index;
        out_d.pht_data = new_ctr;
        out_d.ghr_we   = 1'b1;
        out_d.ghr_data = taken;
      end
      if (btb_need) begin
        out_d.btb_we   = 1'b1;
        out_d.btb_addr = bus.EX_PC;
        out_d.btb_data = {bus.EX_Target[31:2], tag};
      end
      if (is_call) begin
        out_d.ras_call = 1'b1;
        out_d.ras_npc  = seq_pc;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      id_q      <= '0;
      ex_q      <= '0;
      out_q     <= '0;
      byp_vld_q <= 1'b0;
      byp_idx_q <= '0;
      byp_ctr_q <= '0;
    end else begin
      id_q      <= id_d;
      ex_q      <= ex_d;
      out_q     <= out_d;
      byp_vld_q <= byp_vld_d;
      byp_idx_q <= byp_idx_d;
      byp_ctr_q <= byp_ctr_d;
    end
  end

  assign bus.PHT_Write_En         = out_q.pht_we;
  assign bus.PHT_Write_Index      = out_q.pht_idx;
  assign bus.PHT_Write_Data       = out_q.pht_data;
  assign bus.GHR_Write_En         = out_q.ghr_we;
  assign bus.GHR_Write_Data       = out_q.ghr_data;
  assign bus.BTB_Write_En         = out_q.btb_we;
  assign bus.BTB_Write_Addr       = out_q.btb_addr;
  assign bus.BTB_Write_Data       = out_q.btb_data;
  assign bus.RAS_CALL_Inst        = out_q.ras_call;
  assign bus.RAS_CALL_Inst_nextPC = out_q.ras_npc;
  assign bus.RAS_RET_Inst_EX      = out_q.ras_ret;
  assign bus.Branch_Taken__EX_MEM = out_q.br_taken;
  assign bus.Mispredict           = out_q.mispred;
  assign bus.Redirect_PC          = out_q.redirect;

endmodule

// File: tb/tb_bpu_update_unit.sv
// Bench for bpu_update_unit: directed vector table, hand sequences for stall/bypass/flush/reset,
// and randomized traffic checked against a queue-based reference model.
module tb_bpu_update_unit;

  typedef struct packed {
    logic        pht_we;
    logic [10:0] pht_idx;
    logic [1:0]  pht_data;
    logic        ghr_we;
    logic        ghr_data;
    logic        btb_we;
    logic [31:0] btb_addr;
    logic [31:0] btb_data;
    logic        ras_call;
    logic [31:0] ras_npc;
    logic        ras_ret;
    logic        br_taken;
    logic        mispred;
    logic [31:0] redirect;
  } out_t;

  typedef struct packed {
    logic        valid;
    logic [10:0] idx;
    logic [1:0]  ctr;
    logic        hit;
    logic        pt;
    logic [31:0] ptgt;
  } snap_t;

  typedef struct {
    logic        rst_n, stall, flush, if_valid;
    logic [10:0] if_idx;
    logic [1:0]  if_ctr;
    logic        if_hit, if_pt;
    logic [31:0] if_ptgt;
    logic [2:0]  br_type;
    logic [31:0] ex_pc;
    logic        ex_taken;
    logic [31:0] ex_tgt;
  } in_t;

  typedef struct {
    string       name;
    logic [10:0] idx;
    logic [1:0]  ctr;
    logic        hit, pt;
    logic [31:0] ptgt;
    logic [2:0]  br_type;
    logic [31:0] pc;
    logic        taken;
    logic [31:0] tgt;
    out_t        exp;
  } vec_t;

  localparam int OW = $bits(out_t);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;

  logic [OW-1:0] exp_q[$];
  snap_t         m_pipe[$];
  bit            m_hist_v;
  logic [10:0]   m_hist_i;
  logic [1:0]    m_hist_c;
  vec_t          vecs[10];

  always #5 clk = ~clk;

  bpu_update_if bus();
  bpu_update_unit dut (.CLK(clk), .RST(rst_n), .bus(bus));

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- helpers ----------------
  function automatic in_t idle();
    in_t r;
    r.rst_n = 1'b1; r.stall = 1'b0; r.flush = 1'b0; r.if_valid = 1'b0;
    r.if_idx = '0; r.if_ctr = '0; r.if_hit = 1'b0; r.if_pt = 1'b0; r.if_ptgt = '0;
    r.br_type = '0; r.ex_pc = '0; r.ex_taken = 1'b0; r.ex_tgt = '0;
    return r;
  endfunction

  function automatic in_t snap_in(input logic [10:0] idx, input logic [1:0] ctr,
                                  input logic hit, input logic pt, input logic [31:0] ptgt);
    in_t r = idle();
    r.if_valid = 1'b1; r.if_idx = idx; r.if_ctr = ctr;
    r.if_hit = hit; r.if_pt = pt; r.if_ptgt = ptgt;
    return r;
  endfunction

  function automatic in_t ex_in(input logic [2:0] ty, input logic [31:0] pc,
                                input logic tk, input logic [31:0] tgt);
    in_t r = idle();
    r.br_type = ty; r.ex_pc = pc; r.ex_taken = tk; r.ex_tgt = tgt;
    return r;
  endfunction

  function automatic out_t mk_out(input logic pwe, input logic [10:0] pidx, input logic [1:0] pd,
                                  input logic gwe, input logic gd, input logic bwe,
                                  input logic [31:0] ba, input logic [31:0] bd, input logic rc,
                                  input logic [31:0] npc, input logic rr, input logic bt,
                                  input logic mp, input logic [31:0] rpc);
    out_t o;
    o.pht_we = pwe; o.pht_idx = pidx; o.pht_data = pd; o.ghr_we = gwe; o.ghr_data = gd;
    o.btb_we = bwe; o.btb_addr = ba; o.btb_data = bd; o.ras_call = rc; o.ras_npc = npc;
    o.ras_ret = rr; o.br_taken = bt; o.mispred = mp; o.redirect = rpc;
    return o;
  endfunction

  function automatic logic [31:0] pick_tgt();
    case ($urandom_range(0, 3))
      0:       return 32'h0000_0100;
      1:       return 32'h0000_0104;
      2:       return 32'h0000_0103;
      default: return $urandom;
    endcase
  endfunction

  function automatic out_t dut_out();
    out_t o;
    o.pht_we = bus.PHT_Write_En; o.pht_idx = bus.PHT_Write_Index; o.pht_data = bus.PHT_Write_Data;
    o.ghr_we = bus.GHR_Write_En; o.ghr_data = bus.GHR_Write_Data;
    o.btb_we = bus.BTB_Write_En; o.btb_addr = bus.BTB_Write_Addr; o.btb_data = bus.BTB_Write_Data;
    o.ras_call = bus.RAS_CALL_Inst; o.ras_npc = bus.RAS_CALL_Inst_nextPC;
    o.ras_ret = bus.RAS_RET_Inst_EX; o.br_taken = bus.Branch_Taken__EX_MEM;
    o.mispred = bus.Mispredict; o.redirect = bus.Redirect_PC;
    return o;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [OW-1:0] got, input logic [OW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Reference model: the shadow pipe is a 2-deep queue (front = EX), history is the last PHT write.
  task automatic model_edge(input in_t in);
    out_t  e;
    snap_t ex, nw;
    bit    fire, tk;
    int    base;
    logic [1:0] tag;
    e = '0;
    if (!in.rst_n) begin
      m_pipe.delete();
      m_pipe.push_back('0);
      m_pipe.push_back('0);
      m_hist_v = 1'b0;
    end else begin
      ex   = m_pipe[0];
      fire = !in.stall && ex.valid && (in.br_type inside {[3'd1:3'd5]});
      tk   = (in.br_type == 3'd1) ? in.ex_taken : 1'b1;
      if (fire) begin
        e.br_taken = tk;
        e.mispred  = (ex.pt != tk) || (tk && ((ex.ptgt >> 2) != (in.ex_tgt >> 2)));
        e.redirect = tk ? (in.ex_tgt & 32'hFFFF_FFFC) : in.ex_pc + 32'd4;
        if (in.br_type == 3'd1) begin
          base = (m_hist_v && m_hist_i == ex.idx) ? int'(m_hist_c) : int'(ex.ctr);
          if (tk) base = (base == 3) ? 3 : base + 1;
          else    base = (base == 0) ? 0 : base - 1;
          e.pht_we = 1'b1; e.pht_idx = ex.idx; e.pht_data = 2'(base);
          e.ghr_we = 1'b1; e.ghr_data = tk;
        end
        case (in.br_type)
          3'd2, 3'd4: tag = 2'd1;
          3'd3:       tag = 2'd2;
          3'd5:       tag = 2'd3;
          default:    tag = 2'd0;
        endcase
        if (tk && (!ex.hit || ex.ptgt != in.ex_tgt || (!ex.pt && in.br_type != 3'd1))) begin
          e.btb_we = 1'b1; e.btb_addr = in.ex_pc;
          e.btb_data = (in.ex_tgt & 32'hFFFF_FFFC) | {30'd0, tag};
        end
        if (in.br_type == 3'd4) begin
          e.ras_call = 1'b1; e.ras_npc = in.ex_pc + 32'd4;
        end
        e.ras_ret = (in.br_type == 3'd5);
      end
      if (!in.stall) begin
        m_hist_v = fire && (in.br_type == 3'd1);
        m_hist_i = ex.idx;
        m_hist_c = e.pht_data;
        nw = '{valid: in.if_valid, idx: in.if_idx, ctr: in.if_ctr, hit: in.if_hit,
               pt: in.if_pt, ptgt: in.if_ptgt};
        void'(m_pipe.pop_front());
        m_pipe.push_back(nw);
      end
      if (in.flush) begin
        foreach (m_pipe[i]) m_pipe[i].valid = 1'b0;
      end
    end
    exp_q.push_back(e);
  endtask

  // ---------------- driver ----------------
  task automatic drive(input in_t in);
    rst_n = in.rst_n;
    bus.Stall = in.stall; bus.Flush = in.flush; bus.IF_Valid = in.if_valid;
    bus.IF_PHT_Read_Index = in.if_idx; bus.IF_PHT_Read_Data = in.if_ctr;
    bus.IF_BTB_Hit = in.if_hit; bus.IF_Pred_Taken = in.if_pt; bus.IF_Pred_Target = in.if_ptgt;
    bus.EX_Br_Type = in.br_type; bus.EX_PC = in.ex_pc; bus.EX_Taken = in.ex_taken;
    bus.EX_Target = in.ex_tgt;
  endtask

  task automatic step(input in_t in, input string name);
    drive(in);
    @(posedge clk);
    model_edge(in);
    #1;
    check(name, dut_out(), exp_q.pop_front());
  endtask

  // ---------------- test ----------------
  initial begin
    in_t  r;
    out_t o;
    vec_t v;

    vecs[0] = '{"cond_t_01", 11'h155, 2'b01, 1'b0, 1'b0, 32'h0, 3'b001, 32'h1000, 1'b1, 32'h2000,
                mk_out(1, 11'h155, 2'b10, 1, 1, 1, 32'h1000, 32'h2000, 0, 0, 0, 1, 1, 32'h2000)};
    vecs[1] = '{"call_wrap", 11'h0AA, 2'b10, 1'b0, 1'b1, 32'h500, 3'b100, 32'hFFFF_FFFC, 1'b1, 32'h500,
                mk_out(0, 0, 0, 0, 0, 1, 32'hFFFF_FFFC, 32'h501, 1, 32'h0, 0, 1, 0, 32'h500)};
    vecs[2] = '{"ret_tgt", 11'h001, 2'b00, 1'b1, 1'b1, 32'h100, 3'b101, 32'h3000, 1'b1, 32'h104,
                mk_out(0, 0, 0, 0, 0, 1, 32'h3000, 32'h107, 0, 0, 1, 1, 1, 32'h104)};
    vecs[3] = '{"cond_nt_sat0", 11'h7FF, 2'b00, 1'b1, 1'b0, 32'h40, 3'b001, 32'h10, 1'b0, 32'h40,
                mk_out(1, 11'h7FF, 2'b00, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h14)};
    vecs[4] = '{"cond_nt_11", 11'h010, 2'b11, 1'b1, 1'b1, 32'h80, 3'b001, 32'h20, 1'b0, 32'h80,
                mk_out(1, 11'h010, 2'b10, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h24)};
    vecs[5] = '{"jal_ok", 11'h020, 2'b01, 1'b1, 1'b1, 32'h800, 3'b010, 32'h700, 1'b1, 32'h800,
                mk_out(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h800)};
    vecs[6] = '{"jalr_pnt", 11'h030, 2'b01, 1'b1, 1'b0, 32'h900, 3'b011, 32'h880, 1'b1, 32'h900,
                mk_out(0, 0, 0, 0, 0, 1, 32'h880, 32'h902, 0, 0, 0, 1, 1, 32'h900)};
    vecs[7] = '{"cond_lowbits", 11'h040, 2'b11, 1'b1, 1'b1, 32'h1234_5678, 3'b001, 32'h5000, 1'b1,
                32'h1234_567B,
                mk_out(1, 11'h040, 2'b11, 1, 1, 1, 32'h5000, 32'h1234_5678, 0, 0, 0, 1, 0,
                       32'h1234_5678)};
    vecs[8] = '{"type_110", 11'h050, 2'b01, 1'b0, 1'b1, 32'h10, 3'b110, 32'h6000, 1'b1, 32'h20,
                mk_out(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
    vecs[9] = '{"call_hit", 11'h060, 2'b00, 1'b1, 1'b1, 32'h4000, 3'b100, 32'h1234, 1'b1, 32'h4000,
                mk_out(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h1238, 0, 1, 0, 32'h4000)};

    // Reset state
    r = idle(); r.rst_n = 1'b0;
    step(r, "reset0");
    step(r, "reset1");
    o = dut_out();
    check("reset_zero", o, '0);

    // Directed vector table
    for (int i = 0; i < 10; i++) begin
      v = vecs[i];
      step(snap_in(v.idx, v.ctr, v.hit, v.pt, v.ptgt), {v.name, "_load"});
      step(idle(), {v.name, "_id"});
      step(ex_in(v.br_type, v.pc, v.taken, v.tgt), {v.name, "_ex"});
      check(v.name, dut_out(), v.exp);
      step(idle(), {v.name, "_after"});
      check32({v.name, "_pulse"}, {31'd0, bus.PHT_Write_En | bus.BTB_Write_En | bus.Mispredict}, 0);
    end

    // Back-to-back same index: bypass then saturation, then decrement
    step(snap_in(11'h155, 2'b10, 1'b1, 1'b1, 32'h300), "b2b_l1");
    step(snap_in(11'h155, 2'b10, 1'b1, 1'b1, 32'h300), "b2b_l2");
    r = ex_in(3'b001, 32'h2FC, 1'b1, 32'h300);
    r.if_valid = 1'b1; r.if_idx = 11'h155; r.if_ctr = 2'b10; r.if_hit = 1'b1;
    r.if_pt = 1'b1; r.if_ptgt = 32'h300;
    step(r, "b2b_e1");
    check32("b2b_first", {30'd0, bus.PHT_Write_Data}, 32'd3);
    step(ex_in(3'b001, 32'h2FC, 1'b1, 32'h300), "b2b_e2");
    check32("b2b_second", {30'd0, bus.PHT_Write_Data}, 32'd3);
    step(ex_in(3'b001, 32'h2FC, 1'b0, 32'h300), "b2b_e3");
    check32("b2b_third", {30'd0, bus.PHT_Write_Data}, 32'd2);
    check32("b2b_third_mp", {31'd0, bus.Mispredict}, 32'd1);
    check32("b2b_third_rpc", bus.Redirect_PC, 32'h300);
    step(idle(), "b2b_idle");

    // Stall over a resolving branch, then release
    step(snap_in(11'h0F0, 2'b01, 1'b0, 1'b0, 32'h0), "stl_load");
    step(idle(), "stl_id");
    r = ex_in(3'b001, 32'h100, 1'b1, 32'h200); r.stall = 1'b1;
    step(r, "stl_1");
    check32("stall_no_pht", {31'd0, bus.PHT_Write_En}, 0);
    step(r, "stl_2");
    check32("stall_no_ghr", {31'd0, bus.GHR_Write_En}, 0);
    r.stall = 1'b0;
    step(r, "stl_rel");
    check32("stall_rel_pht", {19'd0, bus.PHT_Write_En, bus.PHT_Write_Index, bus.PHT_Write_Data},
            {19'd0, 1'b1, 11'h0F0, 2'b10});
    step(r, "stl_once");
    check32("stall_single", {31'd0, bus.PHT_Write_En}, 0);

    // Flush with branch in ID, then reset during a resolving branch
    step(snap_in(11'h0F1, 2'b01, 1'b0, 1'b0, 32'h0), "fl_load");
    r = idle(); r.flush = 1'b1;
    step(r, "fl_flush");
    step(ex_in(3'b001, 32'h100, 1'b1, 32'h200), "fl_ex");
    check("flush_no_upd", dut_out(), '0);
    step(snap_in(11'h0F2, 2'b01, 1'b0, 1'b0, 32'h0), "rs_load");
    step(idle(), "rs_id");
    r = ex_in(3'b001, 32'h100, 1'b1, 32'h200); r.rst_n = 1'b0;
    step(r, "rs_ex");
    check("reset_mid_upd", dut_out(), '0);
    step(ex_in(3'b001, 32'h100, 1'b1, 32'h200), "rs_after");
    check("reset_drops", dut_out(), '0);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      r = idle();
      r.rst_n    = ($urandom_range(0, 63) != 0);
      r.stall    = ($urandom_range(0, 4) == 0);
      r.flush    = ($urandom_range(0, 9) == 0);
      r.if_valid = ($urandom_range(0, 3) != 0);
      r.if_idx   = 11'($urandom_range(0, 3));
      r.if_ctr   = 2'($urandom_range(0, 3));
      r.if_hit   = 1'($urandom_range(0, 1));
      r.if_pt    = 1'($urandom_range(0, 1));
      r.if_ptgt  = pick_tgt();
      r.br_type  = 3'($urandom_range(0, 7));
      r.ex_pc    = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom;
      r.ex_taken = (r.br_type == 3'b001) ? 1'($urandom_range(0, 1)) : 1'b1;
      r.ex_tgt   = pick_tgt();
      step(r, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
